// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: extension mode encoding and default widths.
package imm_ext_pkg;

    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;

    typedef enum logic [1:0] {
        IMM_SIGN   = 2'd0,
        IMM_ZERO   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate extension: mode mux plus sign/zero flags of the result.
module imm_ext_comb
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] ext,
    output logic             ext_neg,
    output logic             ext_zero
);

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        ext = sext;
        case (mode)
            IMM_SIGN:   ext = sext;
            IMM_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
            IMM_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
            // Word offset to byte offset; the two top bits of sext fall off.
            IMM_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
            default:    ext = sext;
        endcase
    end

    assign ext_neg  = ext[OUT_W-1];
    assign ext_zero = (ext == '0);

endmodule

// File: rtl/imm_extender.sv
// Decode-stage immediate extender, registered by default (one cycle latency).
// Defining IMM_EXT_COMB_EN selects the legacy zero-latency combinational variant.
module imm_extender
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W   // OUT_W >= 2*IN_W so UPPER keeps every imm bit
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] ext,
    output logic             out_valid,
    output logic             ext_neg,
    output logic             ext_zero
);

    // Valid semantics: in_valid qualifies mode/imm in the cycle it is high; there is
    // no ready, every valid input is accepted. out_valid marks ext/flags as fresh;
    // when it is low ext and the flags keep their last value rather than toggling.

    logic [OUT_W-1:0] c_ext;
    logic             c_neg;
    logic             c_zero;

    imm_ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .mode     (mode),
        .imm      (imm),
        .ext      (c_ext),
        .ext_neg  (c_neg),
        .ext_zero (c_zero)
    );

`ifdef IMM_EXT_COMB_EN
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign ext            = c_ext;
    assign ext_neg        = c_neg;
    assign ext_zero       = c_zero;
    assign out_valid      = in_valid;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext       <= '0;
            out_valid <= 1'b0;
            ext_neg   <= 1'b0;
            ext_zero  <= 1'b1;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ext      <= c_ext;
                ext_neg  <= c_neg;
                ext_zero <= c_zero;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_extender.sv
// Self-checking bench for imm_extender (registered build): directed corners plus random traffic.
module tb_imm_extender;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [1:0]       mode;
    logic [IN_W-1:0]  imm;
    logic [OUT_W-1:0] ext;
    logic             out_valid;
    logic             ext_neg;
    logic             ext_zero;

    int n_cmp;
    int n_err;

    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] held;

    imm_extender #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .imm       (imm),
        .ext       (ext),
        .out_valid (out_valid),
        .ext_neg   (ext_neg),
        .ext_zero  (ext_zero)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: interpret imm as a number and apply the mode's arithmetic modulo 2^32.
    function automatic logic [OUT_W-1:0] ref_ext(input int m, input logic [IN_W-1:0] i);
        longint s;
        longint r;
        s = longint'(i);
        if (s >= 32768) s = s - 65536;
        case (m)
            0:       r = s;
            1:       r = longint'(i);
            2:       r = longint'(i) * 65536;
            default: r = s * 4;
        endcase
        return r[OUT_W-1:0];
    endfunction

    task automatic check_outputs(input string tag, input logic v);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".ext"}, ext, held);
        check({tag, ".neg"}, {31'd0, ext_neg}, {31'd0, held[OUT_W-1]});
        check({tag, ".zero"}, {31'd0, ext_zero}, {31'd0, (held == '0)});
    endtask

    // driver: present one input cycle, then check the registered result just after the edge
    task automatic send(input string tag, input logic v, input int m, input logic [IN_W-1:0] i);
        @(negedge clk);
        in_valid = v;
        mode     = m[1:0];
        imm      = i;
        if (v) exp_q.push_back(ref_ext(m, i));
        @(posedge clk);
        #1;
        if (v) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s.queue: got empty expected entry", tag);
            end else begin
                held = exp_q.pop_front();
            end
        end
        check_outputs(tag, v);
    endtask

    task automatic check_reset(input string tag);
        held = '0;
        check_outputs(tag, 1'b0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        held     = '0;
        rst      = 1'b0;
        in_valid = 1'b0;
        mode     = 2'd0;
        imm      = '0;

        #2 rst = 1'b1;
        #1 check_reset("por");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset("idle");

        send("sign_pos",  1'b1, 0, 16'h007D);
        check("sign_pos.lit", ext, 32'h0000007D);
        send("sign_8000", 1'b1, 0, 16'h8000);
        check("sign_8000.lit", ext, 32'hFFFF8000);
        send("sign_7fff", 1'b1, 0, 16'h7FFF);
        check("sign_7fff.lit", ext, 32'h00007FFF);
        send("zero_ffff", 1'b1, 1, 16'hFFFF);
        check("zero_ffff.lit", ext, 32'h0000FFFF);
        send("upper",     1'b1, 2, 16'h1234);
        check("upper.lit", ext, 32'h12340000);
        send("upper_0",   1'b1, 2, 16'h0000);
        send("branch",    1'b1, 3, 16'h0108);
        check("branch.lit", ext, 32'h00000420);
        send("branch_m1", 1'b1, 3, 16'hFFFF);
        check("branch_m1.lit", ext, 32'hFFFFFFFC);
        send("hold_ld",   1'b1, 0, 16'h0084);
        send("hold",      1'b0, 0, 16'h0117);
        check("hold.lit", ext, 32'h00000084);

        // asynchronous reset in the middle of a cycle, no clock edge in between
        send("pre_rst",   1'b1, 0, 16'h8000);
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset("post_rst");

        for (int k = 0; k < 300; k++) begin
            logic [IN_W-1:0] ri;
            case ($urandom_range(0, 5))
                0:       ri = 16'h0000;
                1:       ri = 16'h8000;
                2:       ri = 16'h7FFF;
                3:       ri = 16'hFFFF;
                default: ri = IN_W'($urandom);
            endcase
            send("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), ri);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
